// File: rtl/color_ram_arbiter.sv
// Colour RAM arbiter: video palette lookups own every pixel slot, the CPU is served between slots.
// Build option COLOR_RAM_BLANK_ONLY_EN restricts CPU access to blanking and disables slot stealing.
module color_ram_arbiter #(
    parameter int AW       = 10,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    input  logic          blank,
    input  logic [AW-1:0] vid_addr,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we_b,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic [DW-1:0] pix_data,
    output logic          pix_valid,
    output logic          steal
);

    localparam int WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;
    localparam logic [1:0] ACK     = 2'd3;

    logic [1:0]     state;
    logic [1:0]     state_nxt;
    logic [WCW-1:0] wait_cnt;
    logic           steal_cond;
    logic           cpu_grant;
    logic           vid_slot;
    logic           vid_d1;

`ifdef COLOR_RAM_BLANK_ONLY_EN
    // CPU only touches the RAM during blanking, so video never loses a slot.
    assign steal_cond = 1'b0;
    assign cpu_grant  = (state == ISSUE) && blank && !pix_en;
`else
    logic unused_blank;
    assign unused_blank = blank;
    assign steal_cond = (state == ISSUE) && pix_en && (MAX_WAIT != 0) && (wait_cnt == WAIT_MAX);
    assign cpu_grant  = (state == ISSUE) && (!pix_en || steal_cond);
`endif

    assign vid_slot = pix_en && !steal_cond;

    // RAM port is driven combinationally: the RAM registers the address itself.
    always_comb begin
        ram_addr = '0;
        ram_we_b = 1'b1;
        ram_din  = '0;
        steal    = 1'b0;
        if (!rst) begin
            steal = steal_cond;
            if (vid_slot) begin
                ram_addr = vid_addr;
            end else if (cpu_grant) begin
                ram_addr = cpu_addr;
                if (cpu_we) begin
                    ram_we_b = 1'b0;
                    ram_din  = cpu_wdata;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cpu_req && !cpu_ack) state_nxt = ISSUE;
            ISSUE:   if (cpu_grant) state_nxt = cpu_we ? ACK : RD_WAIT;
            RD_WAIT: state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            vid_d1    <= 1'b0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else begin
            state     <= state_nxt;
            cpu_ack   <= (state_nxt == ACK);
            vid_d1    <= vid_slot;
            pix_valid <= vid_d1;
            if (vid_d1)
                pix_data <= ram_dout;
            if (state == RD_WAIT)
                cpu_rdata <= ram_dout;
            if (state == ACK)
                wait_cnt <= '0;
            else if ((state == ISSUE) && !cpu_grant && pix_en && (wait_cnt != WAIT_MAX))
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_color_ram_arbiter.sv
// Directed self-checking bench for color_ram_arbiter with a behavioural 1-cycle synchronous RAM.
module tb_color_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        pix_en;
    logic        blank;
    logic [9:0]  vid_addr;
    logic        cpu_req;
    logic        cpu_we;
    logic [9:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic [9:0]  ram_addr;
    logic        ram_we_b;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        steal;

    logic [15:0] mem [0:1023];
    logic        tb_we;
    logic [9:0]  tb_addr;
    logic [15:0] tb_data;

    int n_tests = 0;
    int n_fail  = 0;

    color_ram_arbiter #(.AW(10), .DW(16), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .blank(blank), .vid_addr(vid_addr),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .ram_addr(ram_addr), .ram_we_b(ram_we_b),
        .ram_din(ram_din), .ram_dout(ram_dout), .pix_data(pix_data), .pix_valid(pix_valid),
        .steal(steal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tb_we)
            mem[tb_addr] <= tb_data;
        else if (!ram_we_b)
            mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic preload(input logic [9:0] a, input logic [15:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        n_tests++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ack got=%b exp=0", cpu_ack); end
        n_tests++; if (cpu_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_cpu_rdata got=%h exp=0000", cpu_rdata); end
        n_tests++; if (ram_we_b !== 1'b1) begin n_fail++; $display("FAIL reset_ram_we_b got=%b exp=1", ram_we_b); end
        n_tests++; if (ram_addr !== 10'h0) begin n_fail++; $display("FAIL reset_ram_addr got=%h exp=000", ram_addr); end
        n_tests++; if (pix_data !== 16'h0) begin n_fail++; $display("FAIL reset_pix_data got=%h exp=0000", pix_data); end
        n_tests++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pix_valid got=%b exp=0", pix_valid); end
        n_tests++; if (steal !== 1'b0) begin n_fail++; $display("FAIL reset_steal got=%b exp=0", steal); end
        rst = 1'b0;
    endtask

    task automatic test_idle_video();
        logic exp_v;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            pix_en   = ((k % 2) == 0) && (k < 6);
            vid_addr = 10'h155;
            #1;
            exp_v = (k == 2) || (k == 4) || (k == 6);
            n_tests++; if (pix_valid !== exp_v) begin n_fail++; $display("FAIL idle_pix_valid k=%0d got=%b exp=%b", k, pix_valid, exp_v); end
            if (exp_v) begin
                n_tests++; if (pix_data !== 16'h0F0F) begin n_fail++; $display("FAIL idle_pix_data k=%0d got=%h exp=0f0f", k, pix_data); end
            end
            if (pix_en) begin
                n_tests++; if (ram_addr !== 10'h155) begin n_fail++; $display("FAIL idle_ram_addr k=%0d got=%h exp=155", k, ram_addr); end
            end
        end
        pix_en = 1'b0;
    endtask

    task automatic test_cpu_write();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3FF; cpu_wdata = 16'hA5A5; #1;
        n_tests++; if (ram_we_b !== 1'b1) begin n_fail++; $display("FAIL wr_idle_we got=%b exp=1", ram_we_b); end
        @(negedge clk); #1;
        n_tests++; if (ram_we_b !== 1'b0) begin n_fail++; $display("FAIL wr_issue_we got=%b exp=0", ram_we_b); end
        n_tests++; if (ram_addr !== 10'h3FF) begin n_fail++; $display("FAIL wr_issue_addr got=%h exp=3ff", ram_addr); end
        n_tests++; if (ram_din !== 16'hA5A5) begin n_fail++; $display("FAIL wr_issue_din got=%h exp=a5a5", ram_din); end
        n_tests++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL wr_issue_ack got=%b exp=0", cpu_ack); end
        @(negedge clk); #1;
        n_tests++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack got=%b exp=1", cpu_ack); end
        n_tests++; if (ram_we_b !== 1'b1) begin n_fail++; $display("FAIL wr_single_strobe got=%b exp=1", ram_we_b); end
        @(negedge clk);
        cpu_req = 1'b0; #1;
        n_tests++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack_pulse got=%b exp=0", cpu_ack); end
        n_tests++; if (mem[10'h3FF] !== 16'hA5A5) begin n_fail++; $display("FAIL wr_mem got=%h exp=a5a5", mem[10'h3FF]); end
    endtask

    task automatic test_cpu_read();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3FF;
        @(negedge clk); #1;
        n_tests++; if (ram_addr !== 10'h3FF || ram_we_b !== 1'b1) begin n_fail++; $display("FAIL rd_issue got addr=%h we_b=%b exp addr=3ff we_b=1", ram_addr, ram_we_b); end
        @(negedge clk); #1;
        n_tests++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL rd_wait_ack got=%b exp=0", cpu_ack); end
        @(negedge clk); #1;
        n_tests++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL rd_ack got=%b exp=1", cpu_ack); end
        n_tests++; if (cpu_rdata !== 16'hA5A5) begin n_fail++; $display("FAIL rd_data got=%h exp=a5a5", cpu_rdata); end
        @(negedge clk);
        cpu_req = 1'b0; #1;
        n_tests++; if (cpu_ack !== 1'b0 || cpu_rdata !== 16'hA5A5) begin n_fail++; $display("FAIL rd_hold got ack=%b data=%h exp ack=0 data=a5a5", cpu_ack, cpu_rdata); end
    endtask

`ifdef COLOR_RAM_BLANK_ONLY_EN
    task automatic test_blank_only();
        @(negedge clk);
        blank = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h200; cpu_wdata = 16'h1234;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            pix_en = (k == 2);
            vid_addr = 10'h155;
            blank = (k == 4);
            #1;
            n_tests++; if (ram_we_b !== (k != 4)) begin n_fail++; $display("FAIL blank_we k=%0d got=%b exp=%b", k, ram_we_b, k != 4); end
            n_tests++; if (steal !== 1'b0) begin n_fail++; $display("FAIL blank_steal k=%0d got=%b exp=0", k, steal); end
        end
        pix_en = 1'b0;
        @(negedge clk); #1;
        n_tests++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL blank_ack got=%b exp=1", cpu_ack); end
        @(negedge clk);
        cpu_req = 1'b0; blank = 1'b1;
        n_tests++; if (mem[10'h200] !== 16'h1234) begin n_fail++; $display("FAIL blank_mem got=%h exp=1234", mem[10'h200]); end
    endtask
`else
    task automatic test_steal();
        logic [10:0] v_exp;
        logic [15:0] pd_exp [0:10];
        v_exp  = 11'b11101111000;
        pd_exp = '{16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h1000, 16'h1001, 16'h1002,
                   16'h1003, 16'h1003, 16'h1005, 16'h1006, 16'h1007};
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k == 0) begin
                cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h200; cpu_wdata = 16'h1234;
            end
            if (k >= 7) cpu_req = 1'b0;
            pix_en   = (k >= 1) && (k <= 8);
            vid_addr = 10'h100 + 10'(k - 1);
            #1;
            n_tests++; if (steal !== (k == 5)) begin n_fail++; $display("FAIL steal_pulse k=%0d got=%b exp=%b", k, steal, k == 5); end
            n_tests++; if (ram_we_b !== (k != 5)) begin n_fail++; $display("FAIL steal_we k=%0d got=%b exp=%b", k, ram_we_b, k != 5); end
            n_tests++; if (cpu_ack !== (k == 6)) begin n_fail++; $display("FAIL steal_ack k=%0d got=%b exp=%b", k, cpu_ack, k == 6); end
            n_tests++; if (pix_valid !== v_exp[k]) begin n_fail++; $display("FAIL steal_pix_valid k=%0d got=%b exp=%b", k, pix_valid, v_exp[k]); end
            n_tests++; if (pix_data !== pd_exp[k]) begin n_fail++; $display("FAIL steal_pix_data k=%0d got=%h exp=%h", k, pix_data, pd_exp[k]); end
        end
        pix_en = 1'b0;
        n_tests++; if (mem[10'h200] !== 16'h1234) begin n_fail++; $display("FAIL steal_mem got=%h exp=1234", mem[10'h200]); end
    endtask
`endif

    task automatic test_read_conflict();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h200;
        @(negedge clk);
        pix_en = 1'b1; vid_addr = 10'h155; #1;
        n_tests++; if (ram_addr !== 10'h155) begin n_fail++; $display("FAIL rc_video_first got=%h exp=155", ram_addr); end
        @(negedge clk);
        pix_en = 1'b0; #1;
        n_tests++; if (ram_addr !== 10'h200) begin n_fail++; $display("FAIL rc_cpu_issue got=%h exp=200", ram_addr); end
        @(negedge clk); #1;
        n_tests++; if (pix_valid !== 1'b1 || pix_data !== 16'h0F0F) begin n_fail++; $display("FAIL rc_pix got v=%b d=%h exp v=1 d=0f0f", pix_valid, pix_data); end
        n_tests++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL rc_early_ack got=%b exp=0", cpu_ack); end
        @(negedge clk); #1;
        n_tests++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL rc_ack got=%b exp=1", cpu_ack); end
        n_tests++; if (cpu_rdata !== 16'h1234) begin n_fail++; $display("FAIL rc_rdata got=%h exp=1234", cpu_rdata); end
        @(negedge clk);
        cpu_req = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h0AA; cpu_wdata = 16'hBEEF;
        @(negedge clk);
        rst = 1'b1; #1;
        n_tests++; if (ram_we_b !== 1'b1) begin n_fail++; $display("FAIL rstw_we got=%b exp=1", ram_we_b); end
        n_tests++; if (ram_din !== 16'h0) begin n_fail++; $display("FAIL rstw_din got=%h exp=0000", ram_din); end
        @(negedge clk);
        cpu_req = 1'b0; #1;
        n_tests++; if (cpu_rdata !== 16'h0 || pix_data !== 16'h0 || pix_valid !== 1'b0 || cpu_ack !== 1'b0 || ram_addr !== 10'h0)
            begin n_fail++; $display("FAIL rstw_outputs got rdata=%h pix=%h v=%b ack=%b addr=%h exp all 0", cpu_rdata, pix_data, pix_valid, cpu_ack, ram_addr); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            n_tests++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL rstw_no_ack k=%0d got=%b exp=0", k, cpu_ack); end
        end
        n_tests++; if (mem[10'h0AA] !== 16'h5555) begin n_fail++; $display("FAIL rstw_mem got=%h exp=5555", mem[10'h0AA]); end
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0; blank = 1'b1; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        tb_we = 1'b0; tb_addr = '0; tb_data = '0;
        preload(10'h000, 16'h0000);
        preload(10'h155, 16'h0F0F);
        preload(10'h3FF, 16'h0000);
        preload(10'h200, 16'h0000);
        preload(10'h0AA, 16'h5555);
        for (int i = 0; i < 8; i++) preload(10'h100 + 10'(i), 16'h1000 + 16'(i));
        test_reset();
        test_idle_video();
        test_cpu_write();
        test_cpu_read();
`ifdef COLOR_RAM_BLANK_ONLY_EN
        test_blank_only();
`else
        test_steal();
`endif
        test_read_conflict();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
